// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: programmable-length 1-bit delay line with a config
// controller. A new delay is accepted over a valid/ready port. The chain is
// then flushed to zero and refilled, and valid_out is raised once the tap
// holds a sample taken under the active delay.
module delay_line_ctrl #(
  parameter int MAX_LENGTH    = 16,
  parameter int SEL_W         = 5,
  parameter int DEFAULT_DELAY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             datain,
  input  logic             shift_en,
  output logic             dataout,
  output logic             valid_out,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_delay,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [SEL_W-1:0] cur_delay,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [MAX_LENGTH-1:0] sr_q, sr_d;
  logic [SEL_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [SEL_W-1:0]      cur_delay_q, cur_delay_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  cfg_ready_s;
  logic                  cfg_accept_s;
  logic                  cfg_legal_s;
  logic                  fill_done_s;
  logic                  dataout_s;

  // Handshake decode: the legality check runs on the raw request. Only an
  // accepted request has any effect.
  always_comb begin
    cfg_ready_s  = (state_q != ST_FLUSH);
    cfg_accept_s = cfg_valid & cfg_ready_s;
    if ((cfg_delay != {SEL_W{1'b0}}) && (cfg_delay <= SEL_W'(MAX_LENGTH))) begin
      cfg_legal_s = 1'b1;
    end else begin
      cfg_legal_s = 1'b0;
    end
    // cur_delay is never zero, so cur_delay-1 cannot wrap
    if (fill_cnt_q == (cur_delay_q - SEL_W'(1))) begin
      fill_done_s = 1'b1;
    end else begin
      fill_done_s = 1'b0;
    end
  end

  // Shift chain: shifts on shift_en and is wiped while flushing. It otherwise
  // stalls with the rest of the datapath.
  always_comb begin
    sr_d = sr_q;
    if (state_q == ST_FLUSH) begin
      sr_d = {MAX_LENGTH{1'b0}};
    end else if (shift_en) begin
      sr_d = {sr_q[MAX_LENGTH-2:0], datain};
    end else begin
      sr_d = sr_q;
    end
  end

  // Controller next state. A legal accept overrides normal progress,
  // including the FILL->RUN step taken on the same edge.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    cur_delay_d = cur_delay_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (shift_en) begin
          if (fill_done_s) begin
            state_d    = ST_RUN;
            fill_cnt_d = {SEL_W{1'b0}};
          end else begin
            fill_cnt_d = fill_cnt_q + SEL_W'(1);
          end
        end else begin
          fill_cnt_d = fill_cnt_q;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      ST_FLUSH: begin
        // One edge only, whatever shift_en says
        state_d    = ST_FILL;
        fill_cnt_d = {SEL_W{1'b0}};
      end
      default: begin
        // Unreachable encoding: recover through a clean refill
        state_d    = ST_FLUSH;
        fill_cnt_d = {SEL_W{1'b0}};
      end
    endcase

    if (cfg_accept_s) begin
      if (cfg_legal_s) begin
        cur_delay_d = cfg_delay;
        state_d     = ST_FLUSH;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end
  end

  // Tap mux: dataout = sr[cur_delay-1], read straight from the registers
  always_comb begin
    dataout_s = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (cur_delay_q == SEL_W'(i + 1)) begin
        dataout_s = sr_q[i];
      end else begin
        dataout_s = dataout_s;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      sr_q        <= {MAX_LENGTH{1'b0}};
      fill_cnt_q  <= {SEL_W{1'b0}};
      cur_delay_q <= SEL_W'(DEFAULT_DELAY);
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      cur_delay_q <= cur_delay_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign dataout   = dataout_s;
  assign valid_out = (state_q == ST_RUN);
  assign busy      = (state_q != ST_RUN);
  assign cfg_ready = cfg_ready_s;
  assign cfg_err   = cfg_err_q;
  assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl. A behavioural model pushes the
// expected outputs for each edge into a queue as the stimulus is driven. The
// entries are popped and compared #1 after the edge.
module tb_delay_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       datain;
  logic       shift_en;
  logic       dataout;
  logic       valid_out;
  logic       cfg_valid;
  logic [4:0] cfg_delay;
  logic       cfg_ready;
  logic       cfg_err;
  logic [4:0] cur_delay;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       dout;
    logic       valid;
    logic       err;
    logic [4:0] delay;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  // Model state: the sample history since the last flush, the number of
  // shifts since then, and whether a flush is pending.
  logic [15:0] m_hist;
  int          m_since;
  int          m_delay;
  logic        m_flush;
  logic        m_err;

  delay_line_ctrl #(.MAX_LENGTH(16), .SEL_W(5), .DEFAULT_DELAY(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .datain    (datain),
    .shift_en  (shift_en),
    .dataout   (dataout),
    .valid_out (valid_out),
    .cfg_valid (cfg_valid),
    .cfg_delay (cfg_delay),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_delay (cur_delay),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist  = 16'h0000;
    m_since = 0;
    m_delay = 3;
    m_flush = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic v;
    v       = !m_flush && (m_since >= m_delay);
    e.dout  = m_hist[m_delay-1];
    e.valid = v;
    e.err   = m_err;
    e.delay = 5'(m_delay);
    e.busy  = !v;
    e.ready = !m_flush;
    return e;
  endfunction

  // Drive one edge's inputs, advance the model, then compare after the edge
  task automatic step(input logic din, input logic sen, input logic cv, input logic [4:0] cd);
    logic accept;
    logic legal;
    exp_t got;
    exp_t want;
    datain    = din;
    shift_en  = sen;
    cfg_valid = cv;
    cfg_delay = cd;
    accept = cv && !m_flush;
    legal  = (cd >= 5'd1) && (cd <= 5'd16);
    if (m_flush) begin
      m_hist  = 16'h0000;
      m_since = 0;
      m_flush = 1'b0;
    end else if (sen) begin
      m_hist = {m_hist[14:0], din};
      if (m_since < 64) m_since++;
    end
    m_err = accept && !legal;
    if (accept && legal) begin
      m_delay = int'(cd);
      m_flush = 1'b1;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = '{dout: dataout, valid: valid_out, err: cfg_err, delay: cur_delay,
             busy: busy, ready: cfg_ready};
    chk("dataout",   32'(got.dout),  32'(want.dout));
    chk("valid_out", 32'(got.valid), 32'(want.valid));
    chk("cfg_err",   32'(got.err),   32'(want.err));
    chk("cur_delay", 32'(got.delay), 32'(want.delay));
    chk("busy",      32'(got.busy),  32'(want.busy));
    chk("cfg_ready", 32'(got.ready), 32'(want.ready));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dataout"},   32'(dataout),   32'd0);
    chk({tag, "_valid"},     32'(valid_out), 32'd0);
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    chk({tag, "_cur_delay"}, 32'(cur_delay), 32'd3);
    chk({tag, "_busy"},      32'(busy),      32'd1);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    datain    = 1'b0;
    shift_en  = 1'b0;
    cfg_valid = 1'b0;
    cfg_delay = 5'd0;
    model_reset();

    // 1: reset for two cycles, then a run of five ones
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t1_valid_before_edge3", 32'(valid_out), 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t1_valid_at_edge3", 32'(valid_out), 32'd1);
    chk("t1_dout_at_edge3", 32'(dataout), 32'd1);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 5'd0);

    // 2: legal reconfig to 7 in RUN, then a single pulse
    step(1'b0, 1'b1, 1'b1, 5'd7);
    chk("t2_busy_after_accept", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t2_flush_dout", 32'(dataout), 32'd0);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("t2_cur_delay", 32'(cur_delay), 32'd7);

    // 3: illegal requests 0 and 17 in RUN
    step(1'($urandom_range(1)), 1'b1, 1'b1, 5'd0);
    chk("t3_err_zero", 32'(cfg_err), 32'd1);
    step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);
    step(1'($urandom_range(1)), 1'b1, 1'b1, 5'd17);
    chk("t3_err_17", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);

    // 4: stall in FILL with delay 4
    step(1'b1, 1'b1, 1'b1, 5'd4);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b0, 1'b1, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t4_valid_one_after_stall", 32'(valid_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("t4_valid_two_after_stall", 32'(valid_out), 32'd1);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);

    // 5: collision of a legal accept with the FILL->RUN edge, then extremes
    step(1'b0, 1'b1, 1'b1, 5'd5);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 5'd2);
    chk("t5_collision_valid", 32'(valid_out), 32'd0);
    chk("t5_collision_ready", 32'(cfg_ready), 32'd0);
    step(1'b0, 1'b1, 1'b1, 5'd9);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("t5_delay2_valid", 32'(valid_out), 32'd1);
    chk("t5_delay2_cur", 32'(cur_delay), 32'd2);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 5'd1);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t5_delay1_latency", 32'(dataout), 32'd1);
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, 5'd16);
    step(1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("t5_delay16_latency", 32'(dataout), 32'd1);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);

    // 6: async reset in the middle of a FILL with delay 16
    step(1'b1, 1'b1, 1'b1, 5'd16);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
